core_ibex_rvfi_retire_buffer: RTL and testbench

//  Parametrised capture buffer for RVFI retirement records in the core_ibex DV environment.

---
 rtl/core_ibex_rvfi_retire_buffer.sv | 160 ++++++++++++++++
 tb/tb_core_ibex_rvfi_retire_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/core_ibex_rvfi_retire_buffer.sv
// Capture buffer for RVFI retirement records: compacts up to NRET retirements per cycle
// into a FIFO, presents them one at a time and tracks order continuity and overflow drops.
module core_ibex_rvfi_retire_buffer #(
  parameter int unsigned NRET   = 2,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NRET-1:0]            rvfi_valid_i,
  input  logic [NRET*64-1:0]         rvfi_order_i,
  input  logic [NRET*32-1:0]         rvfi_insn_i,
  input  logic [NRET-1:0]            rvfi_trap_i,
  input  logic [NRET*32-1:0]         rvfi_pc_rdata_i,
  input  logic [NRET*32-1:0]         rvfi_pc_wdata_i,
  input  logic [NRET*5-1:0]          rvfi_rd_addr_i,
  input  logic [NRET*32-1:0]         rvfi_rd_wdata_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [63:0]                out_order_o,
  output logic [31:0]                out_insn_o,
  output logic                       out_trap_o,
  output logic [31:0]                out_pc_rdata_o,
  output logic [31:0]                out_pc_wdata_o,
  output logic [4:0]                 out_rd_addr_o,
  output logic [31:0]                out_rd_wdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic [DROP_W-1:0]          drop_cnt_o,
  output logic                       order_err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             lane_rec [NRET];
  logic             slot_en  [NRET];
  logic [PTR_W-1:0] slot_ptr [NRET];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d, free, stored, dropped;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_W:0]   drop_sum;
  logic              overflow_q, order_err_q, order_err_d;
  logic              exp_armed_q, exp_armed_d;
  logic [63:0]       exp_q, exp_d;
  logic              pop;
  rec_t              head;

  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      lane_rec[k] = '{order:    rvfi_order_i[k*64 +: 64],
                      insn:     rvfi_insn_i[k*32 +: 32],
                      trap:     rvfi_trap_i[k],
                      pc_rdata: rvfi_pc_rdata_i[k*32 +: 32],
                      pc_wdata: rvfi_pc_wdata_i[k*32 +: 32],
                      rd_addr:  rvfi_rd_addr_i[k*5 +: 5],
                      rd_wdata: rvfi_rd_wdata_i[k*32 +: 32]};
    end
  end

  // Compaction and order checking walk the lanes in order; dropped lanes are still checked.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    free        = CNT_W'(DEPTH) - count_q;
    stored      = '0;
    dropped     = '0;
    exp_armed_d = exp_armed_q;
    exp_d       = exp_q;
    order_err_d = 1'b0;
    for (int k = 0; k < NRET; k++) begin
      slot_en[k]  = 1'b0;
      slot_ptr[k] = wr_ptr_q + PTR_W'(stored);
      if (rvfi_valid_i[k]) begin
        if (stored < free) begin
          slot_en[k] = 1'b1;
          stored     = stored + CNT_W'(1);
        end else begin
          dropped = dropped + CNT_W'(1);
        end
        if (exp_armed_q || exp_armed_d) begin
          if (lane_rec[k].order != exp_d) order_err_d = 1'b1;
        end
        exp_armed_d = 1'b1;
        exp_d       = lane_rec[k].order + 64'd1;
      end
    end
    pop        = (count_q != '0) && out_ready_i;
    count_d    = count_q + stored - CNT_W'(pop);
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_W+1)'(dropped);
    drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      order_err_q <= 1'b0;
      exp_armed_q <= 1'b0;
      exp_q       <= '0;
    end else if (flush_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      exp_armed_q <= 1'b0;
      exp_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_q + PTR_W'(stored);
      rd_ptr_q    <= rd_ptr_q + PTR_W'(pop);
      count_q     <= count_d;
      overflow_q  <= overflow_q | (dropped != '0);
      drop_cnt_q  <= drop_cnt_d;
      order_err_q <= order_err_q | order_err_d;
      exp_armed_q <= exp_armed_d;
      exp_q       <= exp_d;
    end
  end

  // NOTE: the record storage is not reset; empty-state outputs are forced to zero instead.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int k = 0; k < NRET; k++) begin
        if (slot_en[k]) mem[slot_ptr[k]] <= lane_rec[k];
      end
    end
  end

  assign head           = (count_q != '0) ? mem[rd_ptr_q] : '0;
  assign out_valid_o    = (count_q != '0);
  assign out_order_o    = head.order;
  assign out_insn_o     = head.insn;
  assign out_trap_o     = head.trap;
  assign out_pc_rdata_o = head.pc_rdata;
  assign out_pc_wdata_o = head.pc_wdata;
  assign out_rd_addr_o  = head.rd_addr;
  assign out_rd_wdata_o = head.rd_wdata;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign drop_cnt_o     = drop_cnt_q;
  assign order_err_o    = order_err_q;

endmodule

// File: tb/tb_core_ibex_rvfi_retire_buffer.sv
// Directed bench for the RVFI retire buffer (NRET=2, DEPTH=4 so overflow and pointer wrap are reachable).
module tb_core_ibex_rvfi_retire_buffer;

  localparam int unsigned NRET   = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DROP_W = 16;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NRET-1:0]     rvfi_valid_i;
  logic [NRET*64-1:0]  rvfi_order_i;
  logic [NRET*32-1:0]  rvfi_insn_i;
  logic [NRET-1:0]     rvfi_trap_i;
  logic [NRET*32-1:0]  rvfi_pc_rdata_i;
  logic [NRET*32-1:0]  rvfi_pc_wdata_i;
  logic [NRET*5-1:0]   rvfi_rd_addr_i;
  logic [NRET*32-1:0]  rvfi_rd_wdata_i;
  logic                flush_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [63:0]         out_order_o;
  logic [31:0]         out_insn_o;
  logic                out_trap_o;
  logic [31:0]         out_pc_rdata_o;
  logic [31:0]         out_pc_wdata_o;
  logic [4:0]          out_rd_addr_o;
  logic [31:0]         out_rd_wdata_o;
  logic [2:0]          count_o;
  logic                overflow_o;
  logic [DROP_W-1:0]   drop_cnt_o;
  logic                order_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  core_ibex_rvfi_retire_buffer #(.NRET(NRET), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_order_i(rvfi_order_i), .rvfi_insn_i(rvfi_insn_i),
    .rvfi_trap_i(rvfi_trap_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_pc_wdata_i(rvfi_pc_wdata_i),
    .rvfi_rd_addr_i(rvfi_rd_addr_i), .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_order_o(out_order_o), .out_insn_o(out_insn_o), .out_trap_o(out_trap_o),
    .out_pc_rdata_o(out_pc_rdata_o), .out_pc_wdata_o(out_pc_wdata_o),
    .out_rd_addr_o(out_rd_addr_o), .out_rd_wdata_o(out_rd_wdata_o),
    .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .order_err_o(order_err_o)
  );

  // Record payload is derived from the order so any field can be predicted from it.
  function automatic logic [31:0] insn_of(input logic [63:0] o);
    return {16'hC0DE, o[15:0]};
  endfunction
  function automatic logic [31:0] pc_of(input logic [63:0] o);
    return 32'h8000_0000 + {o[29:0], 2'b00};
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                       input logic rdy, input logic fl);
    logic [63:0] ord [2];
    ord[0] = o0;
    ord[1] = o1;
    rvfi_valid_i = v;
    out_ready_i  = rdy;
    flush_i      = fl;
    for (int k = 0; k < 2; k++) begin
      rvfi_order_i[k*64 +: 64]    = ord[k];
      rvfi_insn_i[k*32 +: 32]     = insn_of(ord[k]);
      rvfi_trap_i[k]              = ord[k][0];
      rvfi_pc_rdata_i[k*32 +: 32] = pc_of(ord[k]);
      rvfi_pc_wdata_i[k*32 +: 32] = pc_of(ord[k]) + 32'd4;
      rvfi_rd_addr_i[k*5 +: 5]    = ord[k][4:0];
      rvfi_rd_wdata_i[k*32 +: 32] = ~ord[k][31:0];
    end
  endtask

  task automatic cycle(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                       input logic rdy, input logic fl);
    drive(v, o0, o1, rdy, fl);
    @(negedge clk_i);
    drive(2'b00, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(2'b00, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk_i);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_order", out_order_o, 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
    check("rst_err", 64'(order_err_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Two lanes at once, then two pops.
    cycle(2'b11, 64'd5, 64'd6, 1'b0, 1'b0);
    check("t1_count", 64'(count_o), 64'd2);
    check("t1_valid", 64'(out_valid_o), 64'd1);
    check("t1_head0", out_order_o, 64'd5);
    cycle(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    check("t1_head1", out_order_o, 64'd6);
    check("t1_count1", 64'(count_o), 64'd1);
    cycle(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    check("t1_empty", 64'(out_valid_o), 64'd0);
    check("t1_err", 64'(order_err_o), 64'd0);

    // Lane 1 only; lane 0 carries a different payload that must not leak through.
    cycle(2'b10, 64'd99, 64'd7, 1'b0, 1'b0);
    check("t2_count", 64'(count_o), 64'd1);
    check("t2_order", out_order_o, 64'd7);
    check("t2_insn", 64'(out_insn_o), 64'hC0DE_0007);
    check("t2_pc", 64'(out_pc_rdata_o), 64'h8000_001C);
    check("t2_pcw", 64'(out_pc_wdata_o), 64'h8000_0020);
    check("t2_rd", 64'(out_rd_addr_o), 64'd7);
    check("t2_trap", 64'(out_trap_o), 64'd1);
    cycle(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    check("t2_empty", 64'(count_o), 64'd0);

    // Fill to 3 across the pointer wrap, then overflow by one lane.
    cycle(2'b11, 64'd8, 64'd9, 1'b0, 1'b0);
    cycle(2'b01, 64'd10, 64'd0, 1'b0, 1'b0);
    check("t4_count3", 64'(count_o), 64'd3);
    cycle(2'b11, 64'd11, 64'd12, 1'b0, 1'b0);
    check("t4_count4", 64'(count_o), 64'd4);
    check("t4_overflow", 64'(overflow_o), 64'd1);
    check("t4_drop", 64'(drop_cnt_o), 64'd1);
    check("t4_err", 64'(order_err_o), 64'd0);
    check("t4_head", out_order_o, 64'd8);
    // Full with a pop in the same cycle: the pop does not make room, 13 is dropped but checked.
    cycle(2'b01, 64'd13, 64'd0, 1'b1, 1'b0);
    check("t4_pop_count", 64'(count_o), 64'd3);
    check("t4_pop_drop", 64'(drop_cnt_o), 64'd2);
    check("t4_pop_head", out_order_o, 64'd9);
    check("t4_pop_err", 64'(order_err_o), 64'd0);
    cycle(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    cycle(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    check("t4_tail", out_order_o, 64'd11);
    check("t4_tail_rdw", 64'(out_rd_wdata_o), 64'hFFFF_FFF4);

    // Flush wins over push and pop; records in the flush cycle are not checked.
    cycle(2'b11, 64'd50, 64'd51, 1'b1, 1'b1);
    check("t5_count", 64'(count_o), 64'd0);
    check("t5_valid", 64'(out_valid_o), 64'd0);
    check("t5_drop", 64'(drop_cnt_o), 64'd0);
    check("t5_overflow", 64'(overflow_o), 64'd0);
    cycle(2'b01, 64'd100, 64'd0, 1'b0, 1'b0);
    check("t5_count1", 64'(count_o), 64'd1);
    check("t5_head", out_order_o, 64'd100);
    check("t5_err", 64'(order_err_o), 64'd0);

    // Gap in order: error after 12, resynchronised so 13 is accepted.
    cycle(2'b00, 64'd0, 64'd0, 1'b0, 1'b1);
    cycle(2'b01, 64'd10, 64'd0, 1'b0, 1'b0);
    check("t3_err_10", 64'(order_err_o), 64'd0);
    cycle(2'b01, 64'd12, 64'd0, 1'b0, 1'b0);
    check("t3_err_12", 64'(order_err_o), 64'd1);
    cycle(2'b01, 64'd13, 64'd0, 1'b0, 1'b0);
    check("t3_err_13", 64'(order_err_o), 64'd1);
    check("t3_count", 64'(count_o), 64'd3);
    check("t3_head", out_order_o, 64'd10);
    cycle(2'b00, 64'd0, 64'd0, 1'b0, 1'b1);
    check("t3_err_sticky", 64'(order_err_o), 64'd1);
    cycle(2'b01, 64'd40, 64'd0, 1'b0, 1'b0);
    check("t6_pre_valid", 64'(out_valid_o), 64'd1);

    // Asynchronous reset mid-stream clears outputs before the next clock edge.
    #2 rst_ni = 1'b0;
    #1;
    check("t6_count", 64'(count_o), 64'd0);
    check("t6_valid", 64'(out_valid_o), 64'd0);
    check("t6_order", out_order_o, 64'd0);
    check("t6_insn", 64'(out_insn_o), 64'd0);
    check("t6_err", 64'(order_err_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle(2'b01, 64'd0, 64'd0, 1'b0, 1'b0);
    check("t6_post_count", 64'(count_o), 64'd1);
    check("t6_post_order", out_order_o, 64'd0);
    check("t6_post_err", 64'(order_err_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
